// File: rtl/riscv_bus_pkg.sv
// Shared encodings for the core's memory bus arbiter.
package riscv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } bus_state_e;

  typedef enum logic {
    OWN_MA = 1'b0,
    OWN_IF = 1'b1
  } bus_own_e;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store ports onto one single-beat bus, drives the
// pipeline stall and a sticky bus-timeout flag.
module mem_port_arbiter
  import riscv_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  input  logic        ma_req_i,
  input  logic        ma_we_i,
  input  logic [31:0] ma_addr_i,
  input  logic [31:0] ma_wdata_i,
  input  logic [3:0]  ma_wstrb_i,
  output logic [31:0] ma_rdata_o,
  output logic        m_req_o,
  output logic        m_we_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  output logic [3:0]  m_wstrb_o,
  input  logic        m_gnt_i,
  input  logic        m_rvalid_i,
  input  logic [31:0] m_rdata_i,
  output logic        m_axi_stall_o,
  output logic        bus_err_o
);

  bus_state_e       r_state;
  bus_own_e         r_own;
  logic             r_ma_srv;
  logic             r_if_srv;
  logic [CNT_W-1:0] r_cnt;
  logic             r_m_req;
  logic             r_m_we;
  logic [31:0]      r_m_addr;
  logic [31:0]      r_m_wdata;
  logic [3:0]       r_m_wstrb;
  logic [31:0]      r_if_rdata;
  logic [31:0]      r_ma_rdata;
  logic             r_bus_err;

  logic             w_ma_pend;
  logic             w_if_pend;
  logic             w_stall;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_done;
  logic             w_abort;
  logic             w_fin;
  logic             w_capture;
  logic [31:0]      w_cap_data;

  assign w_ma_pend = ma_req_i & ~r_ma_srv;
  assign w_if_pend = if_req_i & ~r_if_srv;
  assign w_stall   = w_ma_pend | w_if_pend;
  assign w_cnt_nxt = r_cnt + CNT_W'(1);

  assign w_done = ((r_state == ADDR) & m_gnt_i & m_rvalid_i) |
                  ((r_state == RESP) & m_rvalid_i);
  // A real response in the timeout cycle wins over the abort.
  assign w_abort = ((r_state == ADDR) | (r_state == RESP)) & ~w_done &
                   (w_cnt_nxt == CNT_W'(TIMEOUT));
  assign w_fin      = w_done | w_abort;
  assign w_capture  = w_abort | (w_done & ~r_m_we);
  assign w_cap_data = w_abort ? BUS_ERR_DATA : m_rdata_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_own      <= OWN_MA;
      r_ma_srv   <= 1'b0;
      r_if_srv   <= 1'b0;
      r_cnt      <= '0;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_m_wstrb  <= '0;
      r_if_rdata <= '0;
      r_ma_rdata <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_ma_pend) begin
            r_state   <= ADDR;
            r_own     <= OWN_MA;
            r_cnt     <= '0;
            r_m_req   <= 1'b1;
            r_m_we    <= ma_we_i;
            r_m_addr  <= ma_addr_i;
            r_m_wdata <= ma_wdata_i;
            r_m_wstrb <= ma_wstrb_i;
          end else if (w_if_pend) begin
            r_state   <= ADDR;
            r_own     <= OWN_IF;
            r_cnt     <= '0;
            r_m_req   <= 1'b1;
            r_m_we    <= 1'b0;
            r_m_addr  <= if_addr_i;
            r_m_wdata <= '0;
            r_m_wstrb <= '0;
          end
        end
        ADDR: begin
          r_cnt <= w_cnt_nxt;
          if (w_fin) begin
            r_state <= IDLE;
            r_m_req <= 1'b0;
          end else if (m_gnt_i) begin
            r_state <= RESP;
            r_m_req <= 1'b0;
          end
        end
        RESP: begin
          r_cnt <= w_cnt_nxt;
          if (w_fin) r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_m_req <= 1'b0;
        end
      endcase

      if (w_fin && w_capture) begin
        if (r_own == OWN_MA) r_ma_rdata <= w_cap_data;
        else                 r_if_rdata <= w_cap_data;
      end

      // Flags clear when the pipeline advances; a dropped request must not
      // leave a stale served flag behind.
      if (!w_stall) begin
        r_ma_srv <= 1'b0;
        r_if_srv <= 1'b0;
      end else if (w_fin) begin
        if (r_own == OWN_MA) r_ma_srv <= 1'b1;
        else                 r_if_srv <= 1'b1;
      end

      if (w_abort) r_bus_err <= 1'b1;
    end
  end

  assign m_axi_stall_o = w_stall;
  assign m_req_o       = r_m_req;
  assign m_we_o        = r_m_we;
  assign m_addr_o      = r_m_addr;
  assign m_wdata_o     = r_m_wdata;
  assign m_wstrb_o     = r_m_wstrb;
  assign if_rdata_o    = r_if_rdata;
  assign ma_rdata_o    = r_ma_rdata;
  assign bus_err_o     = r_bus_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT=8).
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        ma_req_i;
  logic        ma_we_i;
  logic [31:0] ma_addr_i;
  logic [31:0] ma_wdata_i;
  logic [3:0]  ma_wstrb_i;
  logic [31:0] ma_rdata_o;
  logic        m_req_o;
  logic        m_we_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic [3:0]  m_wstrb_o;
  logic        m_gnt_i;
  logic        m_rvalid_i;
  logic [31:0] m_rdata_i;
  logic        m_axi_stall_o;
  logic        bus_err_o;

  int total;
  int bad;
  int n_req;
  int req_snap;

  mem_port_arbiter #(
    .TIMEOUT(8),
    .CNT_W  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_rdata_o   (if_rdata_o),
    .ma_req_i     (ma_req_i),
    .ma_we_i      (ma_we_i),
    .ma_addr_i    (ma_addr_i),
    .ma_wdata_i   (ma_wdata_i),
    .ma_wstrb_i   (ma_wstrb_i),
    .ma_rdata_o   (ma_rdata_o),
    .m_req_o      (m_req_o),
    .m_we_o       (m_we_o),
    .m_addr_o     (m_addr_o),
    .m_wdata_o    (m_wdata_o),
    .m_wstrb_o    (m_wstrb_o),
    .m_gnt_i      (m_gnt_i),
    .m_rvalid_i   (m_rvalid_i),
    .m_rdata_i    (m_rdata_i),
    .m_axi_stall_o(m_axi_stall_o),
    .bus_err_o    (bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles with m_req_o high, sampled at each rising edge.
  always @(posedge clk) if (m_req_o) n_req <= n_req + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge: start of the next cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    total = 0; bad = 0; n_req = 0;
    rst = 1'b1;
    if_req_i = 0; if_addr_i = 0;
    ma_req_i = 0; ma_we_i = 0; ma_addr_i = 0; ma_wdata_i = 0; ma_wstrb_i = 0;
    m_gnt_i = 0; m_rvalid_i = 0; m_rdata_i = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_req", 32'(m_req_o), 32'd0);
    chk("rst_m_we", 32'(m_we_o), 32'd0);
    chk("rst_m_addr", m_addr_o, 32'd0);
    chk("rst_m_wdata", m_wdata_o, 32'd0);
    chk("rst_m_wstrb", 32'(m_wstrb_o), 32'd0);
    chk("rst_if_rdata", if_rdata_o, 32'd0);
    chk("rst_ma_rdata", ma_rdata_o, 32'd0);
    chk("rst_stall", 32'(m_axi_stall_o), 32'd0);
    chk("rst_bus_err", 32'(bus_err_o), 32'd0);
    rst = 1'b0;

    // Load only, zero-wait bus
    req_snap = n_req;
    ma_req_i = 1; ma_we_i = 0; ma_addr_i = 32'h100; ma_wstrb_i = 0;
    settle();
    chk("ld_c0_stall", 32'(m_axi_stall_o), 32'd1);
    chk("ld_c0_req", 32'(m_req_o), 32'd0);
    tick();
    chk("ld_c1_req", 32'(m_req_o), 32'd1);
    chk("ld_c1_addr", m_addr_o, 32'h100);
    chk("ld_c1_we", 32'(m_we_o), 32'd0);
    chk("ld_c1_stall", 32'(m_axi_stall_o), 32'd1);
    m_gnt_i = 1;
    tick();
    m_gnt_i = 0;
    chk("ld_c2_req", 32'(m_req_o), 32'd0);
    chk("ld_c2_stall", 32'(m_axi_stall_o), 32'd1);
    m_rvalid_i = 1; m_rdata_i = 32'h1234_5678;
    tick();
    m_rvalid_i = 0; m_rdata_i = 0;
    settle();
    chk("ld_c3_stall", 32'(m_axi_stall_o), 32'd0);
    chk("ld_c3_rdata", ma_rdata_o, 32'h1234_5678);
    tick();
    ma_req_i = 0;
    chk("ld_pulses", 32'(n_req - req_snap), 32'd1);

    // Bus responses while idle are ignored
    m_gnt_i = 1; m_rvalid_i = 1; m_rdata_i = 32'h9999_9999;
    tick();
    m_gnt_i = 0; m_rvalid_i = 0;
    tick();
    chk("idle_req", 32'(m_req_o), 32'd0);
    chk("idle_ma_rdata", ma_rdata_o, 32'h1234_5678);
    chk("idle_if_rdata", if_rdata_o, 32'd0);

    // Simultaneous store and fetch: store first
    req_snap = n_req;
    ma_req_i = 1; ma_we_i = 1; ma_addr_i = 32'h200; ma_wdata_i = 32'hCAFE_F00D;
    ma_wstrb_i = 4'hF;
    if_req_i = 1; if_addr_i = 32'h40;
    settle();
    chk("both_c0_stall", 32'(m_axi_stall_o), 32'd1);
    tick();
    chk("both_c1_req", 32'(m_req_o), 32'd1);
    chk("both_c1_addr", m_addr_o, 32'h200);
    chk("both_c1_we", 32'(m_we_o), 32'd1);
    chk("both_c1_wdata", m_wdata_o, 32'hCAFE_F00D);
    chk("both_c1_wstrb", 32'(m_wstrb_o), 32'hF);
    m_gnt_i = 1;
    tick();
    m_gnt_i = 0;
    m_rvalid_i = 1; m_rdata_i = 32'h5555_5555;
    tick();
    m_rvalid_i = 0;
    settle();
    chk("both_c3_stall", 32'(m_axi_stall_o), 32'd1);
    chk("both_c3_ma_rdata", ma_rdata_o, 32'h1234_5678);
    chk("both_c3_req", 32'(m_req_o), 32'd0);
    tick();
    chk("both_c4_req", 32'(m_req_o), 32'd1);
    chk("both_c4_addr", m_addr_o, 32'h40);
    chk("both_c4_we", 32'(m_we_o), 32'd0);
    chk("both_c4_wstrb", 32'(m_wstrb_o), 32'd0);
    m_gnt_i = 1;
    tick();
    m_gnt_i = 0;
    chk("both_c5_stall", 32'(m_axi_stall_o), 32'd1);
    m_rvalid_i = 1; m_rdata_i = 32'h0000_0013;
    tick();
    m_rvalid_i = 0;
    settle();
    chk("both_c6_stall", 32'(m_axi_stall_o), 32'd0);
    chk("both_c6_if_rdata", if_rdata_o, 32'h0000_0013);
    tick();
    ma_req_i = 0; if_req_i = 0; ma_we_i = 0; ma_wstrb_i = 0;
    chk("both_pulses", 32'(n_req - req_snap), 32'd2);

    // Gnt delayed 4 cycles, rvalid 3 cycles after gnt
    if_req_i = 1; if_addr_i = 32'h80;
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk("dly_wait_req", 32'(m_req_o), 32'd1);
      chk("dly_wait_addr", m_addr_o, 32'h80);
      tick();
    end
    chk("dly_c5_req", 32'(m_req_o), 32'd1);
    m_gnt_i = 1;
    tick();
    m_gnt_i = 0;
    chk("dly_c6_req", 32'(m_req_o), 32'd0);
    tick();
    tick();
    chk("dly_c8_stall", 32'(m_axi_stall_o), 32'd1);
    m_rvalid_i = 1; m_rdata_i = 32'hA5A5_0001;
    tick();
    m_rvalid_i = 0;
    settle();
    chk("dly_c9_stall", 32'(m_axi_stall_o), 32'd0);
    chk("dly_c9_if_rdata", if_rdata_o, 32'hA5A5_0001);
    chk("dly_c9_bus_err", 32'(bus_err_o), 32'd0);
    tick();
    if_req_i = 0;

    // Gnt and rvalid in the same cycle
    ma_req_i = 1; ma_we_i = 0; ma_addr_i = 32'h300;
    tick();
    chk("same_c1_req", 32'(m_req_o), 32'd1);
    m_gnt_i = 1; m_rvalid_i = 1; m_rdata_i = 32'h0F0F_0F0F;
    tick();
    m_gnt_i = 0; m_rvalid_i = 0;
    settle();
    chk("same_c2_stall", 32'(m_axi_stall_o), 32'd0);
    chk("same_c2_rdata", ma_rdata_o, 32'h0F0F_0F0F);
    chk("same_c2_req", 32'(m_req_o), 32'd0);
    tick();
    ma_req_i = 0;
    chk("same_c3_req", 32'(m_req_o), 32'd0);

    // Timeout: gnt never arrives
    ma_req_i = 1; ma_we_i = 0; ma_addr_i = 32'h400;
    tick();
    chk("to_c1_req", 32'(m_req_o), 32'd1);
    repeat (7) tick();
    chk("to_c8_req", 32'(m_req_o), 32'd1);
    chk("to_c8_err", 32'(bus_err_o), 32'd0);
    chk("to_c8_stall", 32'(m_axi_stall_o), 32'd1);
    tick();
    chk("to_c9_req", 32'(m_req_o), 32'd0);
    chk("to_c9_err", 32'(bus_err_o), 32'd1);
    chk("to_c9_rdata", ma_rdata_o, 32'hDEAD_BEEF);
    chk("to_c9_stall", 32'(m_axi_stall_o), 32'd0);
    tick();
    ma_req_i = 0;
    chk("to_sticky_err", 32'(bus_err_o), 32'd1);

    // Reset asserted while in RESP
    if_req_i = 1; if_addr_i = 32'h500;
    tick();
    m_gnt_i = 1;
    tick();
    m_gnt_i = 0;
    chk("rr_c2_req", 32'(m_req_o), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("rr_async_addr", m_addr_o, 32'd0);
    chk("rr_async_err", 32'(bus_err_o), 32'd0);
    chk("rr_async_if_rdata", if_rdata_o, 32'd0);
    chk("rr_async_ma_rdata", ma_rdata_o, 32'd0);
    chk("rr_async_req", 32'(m_req_o), 32'd0);
    tick();
    rst = 1'b0;
    if_addr_i = 32'h600;
    tick();
    chk("rr_new_req", 32'(m_req_o), 32'd1);
    chk("rr_new_addr", m_addr_o, 32'h600);
    m_gnt_i = 1;
    tick();
    m_gnt_i = 0;
    m_rvalid_i = 1; m_rdata_i = 32'h0000_0077;
    tick();
    m_rvalid_i = 0;
    settle();
    chk("rr_new_stall", 32'(m_axi_stall_o), 32'd0);
    chk("rr_new_if_rdata", if_rdata_o, 32'h0000_0077);
    tick();
    if_req_i = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the RV32I core's instruction-fetch port and memory-access (load/store) port onto one shared single-beat memory bus. It sequences each transfer through an address/response state machine and holds returned data in registers. It drives the pipeline-wide `m_axi_stall` signal consumed by the hazard/stall logic, and flags bus timeouts.

## Interface
Parameters:
- `TIMEOUT`, 255 — cycles allowed in ADDR+RESP before a transfer is aborted; must be at least 2.
- `CNT_W`, 8 — timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req_i` in 1 / `if_addr_i` in 32 — fetch request (level); held until the stall drops.
- `if_rdata_o`  out  32  registered fetch data.
- `ma_req_i` in 1 / `ma_we_i` in 1 / `ma_addr_i` in 32 / `ma_wdata_i` in 32 / `ma_wstrb_i` in 4 — data request (level).
- `ma_rdata_o`  out  32  registered load data.
- `m_req_o` out 1 / `m_we_o` out 1 / `m_addr_o` out 32 / `m_wdata_o` out 32 / `m_wstrb_o` out 4 — bus request; all registered.
- `m_gnt_i`  in  1  address accepted.
- `m_rvalid_i`  in  1  response; marks read-data valid or write done.
- `m_rdata_i`  in  32  read data.
- `m_axi_stall_o`  out  1  pipeline stall; combinational.
- `bus_err_o`  out  1  sticky timeout flag; cleared only by reset.

## Operation
- FSM states: IDLE, ADDR, RESP. Owner register: `own` = MA or IF.
- **IDLE**
  - If `ma_req_i & ~ma_srv`, go to ADDR with own=MA. Data has fixed priority because it belongs to the older instruction.
  - Otherwise, if `if_req_i & ~if_srv`, go to ADDR with own=IF.
  - On either transition, register the bus fields and set `m_req_o` to 1.
  - Fetch requests drive `m_we_o`=0 and `m_wstrb_o`=0.
- **ADDR**
  - Hold `m_req_o` and all bus fields stable until `m_gnt_i`.
  - On gnt, drop `m_req_o` and go to RESP.
  - If gnt and `m_rvalid_i` arrive in the same cycle, complete directly.
- **RESP**
  - On `m_rvalid_i`, complete and return to IDLE.
- **Complete**
  - Set the owner's served flag (`ma_srv`/`if_srv`).
  - For a read, capture `m_rdata_i` into the owner's rdata register.
  - For a write, leave the rdata register unchanged.
- **Stall**
  - `m_axi_stall_o = (ma_req_i & ~ma_srv) | (if_req_i & ~if_srv)`.
- **Served flags**
  - Both flags clear on the first edge where `m_axi_stall_o`=0, which is the cycle the pipeline advances.
  - This prevents re-issuing a request that is still held high while the other port is pending.
- **Timeout**
  - The counter resets on entry to ADDR and increments every cycle in ADDR/RESP.
  - When the counter reaches TIMEOUT without completion:
    - abort and drop `m_req_o`;
    - complete the owner with rdata = 32'hDEAD_BEEF;
    - set `bus_err_o`;
    - return to IDLE.
- **Ignored / required inputs**
  - `m_rvalid_i` or `m_gnt_i` in IDLE is ignored.
  - A request that drops before completion is a protocol violation; the FSM still finishes the bus transfer.

## Timing
- Reset values:
  - state=IDLE, own=MA;
  - `m_req_o`, `m_we_o`, `m_addr_o`, `m_wdata_o`, `m_wstrb_o` all 0;
  - `if_rdata_o`, `ma_rdata_o` = 0;
  - served flags, counter and `bus_err_o` = 0.
  - `m_axi_stall_o` follows its combinational equation (0 when no request is present).
- Zero-wait bus, request seen in cycle 0:
  - `m_req_o` high in cycle 1;
  - gnt in cycle 1, rvalid in cycle 2;
  - stall high in cycles 0–2; data on the rdata output and stall low in cycle 3.
  - Minimum 3 stall cycles per single transfer.
- Both requests in cycle 0 (zero-wait bus): MA completes in cycle 2 and IF in cycle 5, so stall is low in cycle 6.
- Each rdata output holds its value until the next completion for that port.
- Reset asserted mid-transfer: outputs and state return to reset values immediately; no response is expected afterwards.

## Structure
- Shared package `riscv_bus_pkg` holds:
  - state encoding (IDLE=2'd0, ADDR=2'd1, RESP=2'd2);
  - owner encoding (OWN_MA=1'b0, OWN_IF=1'b1);
  - `BUS_ERR_DATA` = 32'hDEAD_BEEF.
- Single module; no sub-module is needed. The counter is inline.

## Test plan
- Load only (`ma_req_i`=1, we=0, addr 0x100), zero-wait bus returning 0x12345678 → stall in cycles 0–2, `ma_rdata_o`=0x12345678 in cycle 3, exactly one `m_req_o` pulse.
- Simultaneous fetch (0x40) and store (0x200, wdata 0xCAFEF00D, wstrb 4'hF) → store issued first, fetch second, one bus transaction each, stall low only after the fetch completes.
- Gnt delayed 4 cycles, rvalid 3 cycles after that → `m_addr_o` and `m_req_o` stable for all 4 wait cycles, stall released one cycle after rvalid.
- Gnt and rvalid in the same cycle → completion in that cycle, FSM back in IDLE on the next edge.
- TIMEOUT=8 with gnt never asserted → abort after 8 cycles, `bus_err_o`=1, `ma_rdata_o`=0xDEADBEEF, stall released.
- `rst` pulsed while in RESP → all outputs zero asynchronously, and a new fetch issues normally after reset is released.
